// File: rtl/varray_write_arbiter.sv
// Write-port arbiter for one varray: allocates contiguous virtual address runs to NUM_REQ producers under credit control.
// Define VARRAY_ARB_FIXED_PRIO_EN for fixed lowest-index priority; otherwise round-robin.
module varray_write_arbiter #(
    parameter int NUM_REQ               = 2,
    parameter int VIRTUAL_ELEMENT_WIDTH = 18,
    parameter int VIRTUAL_ADDR_BITS     = 16,
    parameter int QUEUE_DEPTH           = 64,
    parameter int MAX_RUN               = 16
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [NUM_REQ-1:0]                       req_valid,
    input  logic [NUM_REQ*5-1:0]                     req_len,
    input  logic [NUM_REQ*VIRTUAL_ELEMENT_WIDTH-1:0] req_dat,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic                                     entry_retire,
    output logic                                     varray_we,
    output logic [VIRTUAL_ADDR_BITS-1:0]             varray_write_addr,
    output logic [4:0]                               varray_write_len,
    output logic [VIRTUAL_ELEMENT_WIDTH-1:0]         varray_dat_w,
    output logic [VIRTUAL_ADDR_BITS-1:0]             next_addr,
    output logic [$clog2(QUEUE_DEPTH)-1:0]           credits,
    output logic                                     exhausted,
    output logic                                     err_len,
    output logic                                     err_retire
);
    localparam int EW  = VIRTUAL_ELEMENT_WIDTH;
    localparam int AW  = VIRTUAL_ADDR_BITS;
    localparam int CW  = $clog2(QUEUE_DEPTH);
    localparam int RRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CW-1:0] CRED_MAX   = CW'(QUEUE_DEPTH - 1);
    localparam logic [AW:0]   ADDR_LIMIT = (AW+1)'((2**AW) - 1 - MAX_RUN);

    typedef struct packed {
        logic [4:0]    len;
        logic [EW-1:0] dat;
    } req_t;

    req_t [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] legal;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic [RRW-1:0]     gnt_idx;
    logic [RRW-1:0]     rr;
    logic               gnt_any;
    logic               gnt_legal;
    req_t               sel;
    logic [AW:0]        addr_sum;

    // Illegal lengths bypass the credit check so they can always be drained.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign req[i].len = req_len[5*i +: 5];
        assign req[i].dat = req_dat[EW*i +: EW];
        assign legal[i]   = (req[i].len != 5'd0) && (req[i].len <= 5'(MAX_RUN));
        assign elig[i]    = req_valid[i] && !exhausted && (!legal[i] || (credits != '0));
    end

    always_comb begin
        int j;
        gnt     = '0;
        gnt_idx = '0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef VARRAY_ARB_FIXED_PRIO_EN
            j = k;
`else
            j = (int'(rr) + k) % NUM_REQ;
`endif
            if (gnt == '0 && elig[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = RRW'(j);
            end
        end
    end

    assign req_ready = gnt;
    assign gnt_any   = |gnt;
    assign gnt_legal = |(gnt & legal);
    assign sel       = req[gnt_idx];
    // One extra bit so the exhaustion compare sees the true sum.
    assign addr_sum  = {1'b0, next_addr} + (AW+1)'(sel.len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            varray_we         <= 1'b0;
            varray_write_addr <= '0;
            varray_write_len  <= '0;
            varray_dat_w      <= '0;
            next_addr         <= '0;
            credits           <= CRED_MAX;
            exhausted         <= 1'b0;
            err_len           <= 1'b0;
            err_retire        <= 1'b0;
            rr                <= '0;
        end else begin
            varray_we <= gnt_legal;
            err_len   <= gnt_any && !gnt_legal;
            if (gnt_legal) begin
                varray_write_addr <= next_addr;
                varray_write_len  <= sel.len;
                varray_dat_w      <= sel.dat;
                next_addr         <= addr_sum[AW-1:0];
                if (addr_sum > ADDR_LIMIT)
                    exhausted <= 1'b1;
            end
            if (gnt_legal && !entry_retire)
                credits <= credits - 1'b1;
            else if (!gnt_legal && entry_retire) begin
                if (credits == CRED_MAX)
                    err_retire <= 1'b1;
                else
                    credits <= credits + 1'b1;
            end
`ifdef VARRAY_ARB_FIXED_PRIO_EN
            rr <= '0;
`else
            if (gnt_any)
                rr <= RRW'((int'(gnt_idx) + 1) % NUM_REQ);
`endif
        end
    end
endmodule

// File: tb/tb_varray_write_arbiter.sv
// Directed bench for varray_write_arbiter: grants, credits, illegal lengths, exhaustion and async reset.
module tb_varray_write_arbiter;
    localparam int NR = 2;
    localparam int EW = 18;
    localparam int AW = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR*5-1:0]   req_len;
    logic [NR*EW-1:0]  req_dat;
    logic [NR-1:0]     req_ready;
    logic              entry_retire;
    logic              varray_we;
    logic [AW-1:0]     varray_write_addr;
    logic [4:0]        varray_write_len;
    logic [EW-1:0]     varray_dat_w;
    logic [AW-1:0]     next_addr;
    logic [5:0]        credits;
    logic              exhausted;
    logic              err_len;
    logic              err_retire;

    int checks = 0;
    int errors = 0;

    varray_write_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_len(req_len), .req_dat(req_dat),
        .req_ready(req_ready), .entry_retire(entry_retire), .varray_we(varray_we),
        .varray_write_addr(varray_write_addr), .varray_write_len(varray_write_len),
        .varray_dat_w(varray_dat_w), .next_addr(next_addr), .credits(credits),
        .exhausted(exhausted), .err_len(err_len), .err_retire(err_retire)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid    = '0;
        req_len      = '0;
        req_dat      = '0;
        entry_retire = 1'b0;
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int cnt;
        logic [NR-1:0] exp_g [4];
        reset_n      = 1'b0;
        req_valid    = '0;
        req_len      = '0;
        req_dat      = '0;
        entry_retire = 1'b0;
        #12;
        chk("rst_we", varray_we, 0);
        chk("rst_addr", varray_write_addr, 0);
        chk("rst_len", varray_write_len, 0);
        chk("rst_dat", varray_dat_w, 0);
        chk("rst_next", next_addr, 0);
        chk("rst_cred", credits, 63);
        chk("rst_exh", exhausted, 0);
        chk("rst_errlen", err_len, 0);
        chk("rst_errret", err_retire, 0);
        reset_n = 1'b1;
        tick();

        // 1: single run
        req_valid = 2'b01; req_len[4:0] = 5'd4; req_dat[EW-1:0] = 18'h155;
        #1 chk("t1_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        chk("t1_we", varray_we, 1);
        chk("t1_addr", varray_write_addr, 0);
        chk("t1_len", varray_write_len, 4);
        chk("t1_dat", varray_dat_w, 18'h155);
        chk("t1_next", next_addr, 4);
        chk("t1_cred", credits, 62);

        // 2: two requesters contending
        do_reset();
`ifdef VARRAY_ARB_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        req_valid = 2'b11; req_len = {5'd2, 5'd2}; req_dat = {18'h00022, 18'h00011};
        for (int k = 0; k < 4; k++) begin
            #1 chk("t2_ready", req_ready, exp_g[k]);
            tick();
            chk("t2_we", varray_we, 1);
            chk("t2_addr", varray_write_addr, 32'(2*k));
            chk("t2_dat", varray_dat_w, (exp_g[k] == 2'b01) ? 18'h11 : 18'h22);
        end
        req_valid = '0;
        chk("t2_cred", credits, 59);

        // 3: credit starvation and single-retire refill
        do_reset();
        req_valid = 2'b01; req_len[4:0] = 5'd1;
        cnt = 0;
        for (int k = 0; k < 63; k++) begin
            #1 if (req_ready[0]) cnt++;
            tick();
        end
        chk("t3_grants", cnt, 63);
        chk("t3_cred0", credits, 0);
        chk("t3_next", next_addr, 63);
        #1 chk("t3_stall", req_ready, 0);
        entry_retire = 1'b1;
        tick();
        entry_retire = 1'b0;
        chk("t3_cred1", credits, 1);
        #1 chk("t3_regrant", req_ready, 2'b01);
        tick();
        chk("t3_we", varray_we, 1);
        chk("t3_addr", varray_write_addr, 63);
        #1 chk("t3_stall2", req_ready, 0);
        tick();
        chk("t3_we0", varray_we, 0);
        req_valid = '0;

        // 4: illegal lengths are dropped
        do_reset();
        req_valid = 2'b01; req_len[4:0] = 5'd0;
        #1 chk("t4_ready0", req_ready, 2'b01);
        tick();
        req_len[4:0] = 5'd17;
        chk("t4_err0", err_len, 1);
        chk("t4_we0", varray_we, 0);
        #1 chk("t4_ready17", req_ready, 2'b01);
        tick();
        req_valid = '0;
        chk("t4_err17", err_len, 1);
        chk("t4_we17", varray_we, 0);
        tick();
        chk("t4_errclr", err_len, 0);
        chk("t4_next", next_addr, 0);
        chk("t4_cred", credits, 63);

        // 5: address exhaustion
        do_reset();
        req_valid = 2'b01; req_len[4:0] = 5'd16; entry_retire = 1'b1;
        for (int k = 0; k < 4094; k++) tick();
        req_len[4:0] = 5'd6;
        tick();
        entry_retire = 1'b0;
        chk("t5_next", next_addr, 65510);
        chk("t5_cred", credits, 63);
        chk("t5_exh0", exhausted, 0);
        req_len[4:0] = 5'd10;
        tick();
        req_valid = '0;
        chk("t5_we", varray_we, 1);
        chk("t5_addr", varray_write_addr, 65510);
        chk("t5_len", varray_write_len, 10);
        chk("t5_exh", exhausted, 1);
        chk("t5_next2", next_addr, 65520);
        req_valid = 2'b11; req_len = {5'd0, 5'd1};
        #1 chk("t5_noready", req_ready, 0);
        tick();
        chk("t5_nowe", varray_we, 0);
        req_valid = '0;

        // 6: async reset mid-stream, then retire overflow
        do_reset();
        req_valid = 2'b01; req_len[4:0] = 5'd3; req_dat[EW-1:0] = 18'h3ABC;
        tick();
        tick();
        chk("t6_pre_next", next_addr, 6);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_we", varray_we, 0);
        chk("t6_addr", varray_write_addr, 0);
        chk("t6_dat", varray_dat_w, 0);
        chk("t6_next", next_addr, 0);
        chk("t6_cred", credits, 63);
        req_valid = '0;
        reset_n = 1'b1;
        tick();
        entry_retire = 1'b1;
        tick();
        entry_retire = 1'b0;
        chk("t6_errret", err_retire, 1);
        chk("t6_credmax", credits, 63);
        tick();
        chk("t6_sticky", err_retire, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
